fc_result_reader: RTL and testbench
===================================

FC_RESULT_READER -- requirements
Module: fc_result_reader

Interface
REQ-001 Parameters SHALL be: CLASS_NUM, 10, number of FC2 output classes.
REQ-002 DATA_WIDTH, 8, bits per class score.
REQ-003 DATA_NUM_PER_SRAM_ADDR, 4, scores packed per SRAM f word.
REQ-004 BASE_ADDR, 10'd0, SRAM f address holding class 0.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 srstn  in  1  reset, asynchronous, active-low.
REQ-007 fc2_done  in  1  one-cycle pulse from FC stage: SRAM f fully written.
REQ-008 sram_raddr_f  out  10  SRAM f read address, registered.
REQ-009 sram_rdata_f  in  32  SRAM f read data, valid one cycle after the address edge.
REQ-010 result_class  out  4  index of the maximum score.
REQ-011 result_score  out  8  maximum score, signed two's complement.
REQ-012 result_valid  out  1  result available; held until accepted.
REQ-013 result_ready  in  1  consumer accepts the result.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Class k SHALL be read from address BASE_ADDR + k/4, byte lane k%4; lane 0 = bits [31:24], lane 3 = bits [7:0].
REQ-016 Scores SHALL be compared as signed 8-bit values.
REQ-017 On ties, the lowest class index SHALL win (update only on strictly greater).
REQ-018 Lanes beyond CLASS_NUM-1 in the last word (classes 10, 11) SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, READ, DONE.
REQ-020 IDLE: sram_raddr_f = BASE_ADDR; fc2_done high -> READ, raddr <= BASE_ADDR, running max cleared to (score = -128, class = 0, first-valid flag cleared).
REQ-021 READ: issue ceil(CLASS_NUM/4) = 3 consecutive addresses, one per cycle; a 1-cycle delayed read-valid pipe folds all 4 lanes of each returned word into the running max in one cycle.
REQ-022 The first valid lane SHALL load the running max unconditionally, so an all -128 vector yields class 0.
REQ-023 After the last word is folded -> DONE, result_valid <= 1.
REQ-024 Latency: fc2_done sampled at edge N -> result_valid high after edge N+4.
REQ-025 DONE: result_class and result_score SHALL be stable while result_valid is high.
REQ-026 DONE: on an edge with result_valid & result_ready -> IDLE, result_valid <= 0.
REQ-027 fc2_done outside IDLE SHALL be ignored, including in the handshake cycle.
REQ-028 result_ready outside DONE SHALL be ignored.
REQ-029 sram_raddr_f SHALL never exceed BASE_ADDR + 2.

Reset
REQ-030 srstn low SHALL asynchronously force: state IDLE, sram_raddr_f = BASE_ADDR, result_class = 0, result_score = 0, result_valid = 0, busy = 0, read-valid pipe cleared.
REQ-031 Reset mid-READ or mid-DONE SHALL abort the operation with no partial result; the next fc2_done restarts from class 0.

Structure
REQ-032 A shared package lenet_fc_pkg SHALL hold CLASS_NUM, DATA_WIDTH, DATA_NUM_PER_SRAM_ADDR, the lane-order definition and the FSM state encoding.
REQ-033 A combinational sub-module fc_argmax_lane SHALL take 4 lane scores, a lane-valid mask, the incoming max and the incoming first flag, and return the updated max, class and flag.

Verification
REQ-034 Scores 0..9 = {1,2,3,4,5,6,7,8,9,10}, fc2_done pulse -> addresses 0,1,2 on successive cycles; result_class = 9, score = 10, valid after edge N+4.
REQ-035 All scores -5 except class 6 = -3 and class 3 = -3 -> class 3, score -3 (tie, lowest index).
REQ-036 All scores 8'h80, lanes 10/11 = 8'h7F -> class 0, score -128 (padding lanes ignored).
REQ-037 Hold result_ready low 20 cycles, pulse fc2_done during DONE -> outputs stable and no new read; ready high -> IDLE next edge.
REQ-038 Assert srstn low during the second READ cycle -> all outputs at reset values immediately; a new fc2_done gives a correct full result.

Source files
------------

// File: rtl/lenet_fc_pkg.sv
// Shared LeNet FC-stage definitions: score geometry, SRAM lane order and reader FSM states.
package lenet_fc_pkg;

  localparam int CLASS_NUM              = 10;
  localparam int DATA_WIDTH             = 8;
  localparam int DATA_NUM_PER_SRAM_ADDR = 4;
  localparam int WORD_WIDTH             = DATA_WIDTH * DATA_NUM_PER_SRAM_ADDR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fc_state_t;

  // Lane 0 sits in the most significant byte of an SRAM word.
  function automatic logic signed [DATA_WIDTH-1:0] lane_score(
    input logic [WORD_WIDTH-1:0] word,
    input int                    lane
  );
    return word[(DATA_NUM_PER_SRAM_ADDR-1-lane)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [DATA_NUM_PER_SRAM_ADDR-1:0] lane_valid_mask(
    input int first_class,
    input int class_num
  );
    logic [DATA_NUM_PER_SRAM_ADDR-1:0] mask;
    mask = '0;
    for (int l = 0; l < DATA_NUM_PER_SRAM_ADDR; l++) begin
      mask[l] = (first_class + l) < class_num;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fc_argmax_lane.sv
// Folds one SRAM word (all lanes at once) into a running signed argmax.
module fc_argmax_lane
  import lenet_fc_pkg::*;
(
  input  logic [WORD_WIDTH-1:0]             lane_word,
  input  logic [DATA_NUM_PER_SRAM_ADDR-1:0] lane_valid,
  input  logic [3:0]                        base_class,
  input  logic signed [DATA_WIDTH-1:0]      max_score_in,
  input  logic [3:0]                        max_class_in,
  input  logic                              first_seen_in,
  output logic signed [DATA_WIDTH-1:0]      max_score_out,
  output logic [3:0]                        max_class_out,
  output logic                              first_seen_out
);

  logic signed [DATA_WIDTH-1:0] lane_val;

  // Strictly-greater update keeps the lowest index on ties; the first valid lane always loads.
  always_comb begin
    max_score_out  = max_score_in;
    max_class_out  = max_class_in;
    first_seen_out = first_seen_in;
    lane_val       = '0;
    for (int l = 0; l < DATA_NUM_PER_SRAM_ADDR; l++) begin
      lane_val = lane_score(lane_word, l);
      if (lane_valid[l] && (!first_seen_out || (lane_val > max_score_out))) begin
        max_score_out  = lane_val;
        max_class_out  = base_class + 4'(l);
        first_seen_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_result_reader.sv
// Reads the FC2 class scores back from SRAM f and presents the argmax with a valid/ready handshake.
module fc_result_reader
  import lenet_fc_pkg::*;
#(
  parameter int         CLASS_NUM              = lenet_fc_pkg::CLASS_NUM,
  parameter int         DATA_WIDTH             = lenet_fc_pkg::DATA_WIDTH,
  parameter int         DATA_NUM_PER_SRAM_ADDR = lenet_fc_pkg::DATA_NUM_PER_SRAM_ADDR,
  parameter logic [9:0] BASE_ADDR              = 10'd0
) (
  input  logic                                         clk,
  input  logic                                         srstn,
  input  logic                                         fc2_done,
  output logic [9:0]                                   sram_raddr_f,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
  output logic [3:0]                                   result_class,
  output logic [DATA_WIDTH-1:0]                        result_score,
  output logic                                         result_valid,
  input  logic                                         result_ready,
  output logic                                         busy
);

  localparam int WORD_NUM = (CLASS_NUM + DATA_NUM_PER_SRAM_ADDR - 1) / DATA_NUM_PER_SRAM_ADDR;
  localparam int CNT_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_NUM - 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  fc_state_t state, next_state;

  logic [CNT_W-1:0]                  issue_idx;
  logic                              issue_done;
  logic                              rd_valid;
  logic [CNT_W-1:0]                  rd_word;
  logic signed [DATA_WIDTH-1:0]      max_score;
  logic [3:0]                        max_class;
  logic                              max_seen;
  logic signed [DATA_WIDTH-1:0]      fold_score;
  logic [3:0]                        fold_class;
  logic                              fold_seen;
  logic [DATA_NUM_PER_SRAM_ADDR-1:0] lane_valid;
  logic [3:0]                        base_class;
  logic                              last_fold;

  assign lane_valid = lane_valid_mask(int'(rd_word) * DATA_NUM_PER_SRAM_ADDR, CLASS_NUM);
  assign base_class = 4'(int'(rd_word) * DATA_NUM_PER_SRAM_ADDR);
  assign last_fold  = rd_valid && (rd_word == LAST_WORD);
  assign busy       = (state != IDLE);

  fc_argmax_lane u_argmax (
    .lane_word      (sram_rdata_f),
    .lane_valid     (lane_valid),
    .base_class     (base_class),
    .max_score_in   (max_score),
    .max_class_in   (max_class),
    .first_seen_in  (max_seen),
    .max_score_out  (fold_score),
    .max_class_out  (fold_class),
    .first_seen_out (fold_seen)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fc2_done) next_state = READ;
      READ:    if (last_fold) next_state = DONE;
      DONE:    if (result_valid && result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rd_valid/rd_word trail the issued address by one cycle to line up with the SRAM read latency.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      sram_raddr_f <= BASE_ADDR;
      issue_idx    <= '0;
      issue_done   <= 1'b0;
      rd_valid     <= 1'b0;
      rd_word      <= '0;
      max_score    <= MIN_SCORE;
      max_class    <= 4'd0;
      max_seen     <= 1'b0;
      result_class <= 4'd0;
      result_score <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sram_raddr_f <= BASE_ADDR;
          issue_idx    <= '0;
          issue_done   <= 1'b0;
          rd_valid     <= 1'b0;
          if (fc2_done) begin
            max_score <= MIN_SCORE;
            max_class <= 4'd0;
            max_seen  <= 1'b0;
          end
        end
        READ: begin
          rd_valid <= !issue_done;
          rd_word  <= issue_idx;
          if (!issue_done) begin
            if (issue_idx == LAST_WORD) begin
              issue_done <= 1'b1;
            end else begin
              issue_idx    <= issue_idx + 1'b1;
              sram_raddr_f <= BASE_ADDR + 10'(issue_idx) + 10'd1;
            end
          end
          if (rd_valid) begin
            max_score <= fold_score;
            max_class <= fold_class;
            max_seen  <= fold_seen;
          end
          if (last_fold) begin
            result_class <= fold_class;
            result_score <= fold_score;
            result_valid <= 1'b1;
            sram_raddr_f <= BASE_ADDR;
          end
        end
        DONE: begin
          rd_valid <= 1'b0;
          if (result_valid && result_ready) result_valid <= 1'b0;
        end
        default: rd_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_result_reader.sv
// Directed bench for fc_result_reader with a one-cycle-latency SRAM f model.
module tb_fc_result_reader;

  logic        clk;
  logic        srstn;
  logic        fc2_done;
  logic [9:0]  sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic [3:0]  result_class;
  logic [7:0]  result_score;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  logic [31:0] mem [0:3];
  int          total;
  int          bad;
  logic        raddr_over;

  fc_result_reader dut (
    .clk          (clk),
    .srstn        (srstn),
    .fc2_done     (fc2_done),
    .sram_raddr_f (sram_raddr_f),
    .sram_rdata_f (sram_rdata_f),
    .result_class (result_class),
    .result_score (result_score),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f[1:0]];

  always @(negedge clk) if (sram_raddr_f > 10'd2) raddr_over = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Class 0 is the most significant byte of the 96-bit score vector.
  task automatic applyStimulus(input logic [95:0] scores);
    for (int w = 0; w < 3; w++) mem[w] = scores[95-32*w -: 32];
    mem[3] = 32'd0;
    @(negedge clk) fc2_done = 1'b1;
    @(negedge clk) fc2_done = 1'b0;
  endtask

  task automatic waitValid(output logic got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (result_valid) got = 1'b1;
    end
  endtask

  task automatic runCase(input string tag, input logic [95:0] scores,
                         input logic [3:0] exp_class, input logic [7:0] exp_score);
    logic got;
    applyStimulus(scores);
    waitValid(got);
    checkOutput({tag, "_valid"}, 32'(got), 32'd1);
    checkOutput({tag, "_class"}, 32'(result_class), 32'(exp_class));
    checkOutput({tag, "_score"}, 32'(result_score), 32'(exp_score));
    result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
    checkOutput({tag, "_released"}, {30'd0, result_valid, busy}, 32'd0);
  endtask

  logic [95:0] vec_ramp;
  logic [95:0] vec_tie;
  logic [95:0] vec_min;
  logic [95:0] vec_sign;
  logic        stable;
  logic        got_valid;

  initial begin
    total        = 0;
    bad          = 0;
    raddr_over   = 1'b0;
    srstn        = 1'b0;
    fc2_done     = 1'b0;
    result_ready = 1'b0;
    for (int w = 0; w < 4; w++) mem[w] = 32'd0;

    vec_ramp = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd0, 8'd0};
    vec_tie  = {8'hFB, 8'hFB, 8'hFB, 8'hFD, 8'hFB, 8'hFB, 8'hFD, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB};
    vec_min  = {{10{8'h80}}, 8'h7F, 8'h7F};
    vec_sign = {8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (2) @(negedge clk);
    checkOutput("rst_raddr", 32'(sram_raddr_f), 32'd0);
    checkOutput("rst_class", 32'(result_class), 32'd0);
    checkOutput("rst_score", 32'(result_score), 32'd0);
    checkOutput("rst_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    srstn = 1'b1;
    @(negedge clk);

    // Ramp: address sequence and exact latency.
    applyStimulus(vec_ramp);
    checkOutput("ramp_a0", 32'(sram_raddr_f), 32'd0);
    checkOutput("ramp_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("ramp_a1", 32'(sram_raddr_f), 32'd1);
    @(negedge clk);
    checkOutput("ramp_a2", 32'(sram_raddr_f), 32'd2);
    @(negedge clk);
    checkOutput("ramp_early", 32'(result_valid), 32'd0);
    @(negedge clk);
    checkOutput("ramp_valid", 32'(result_valid), 32'd1);
    checkOutput("ramp_class", 32'(result_class), 32'd9);
    checkOutput("ramp_score", 32'(result_score), 32'd10);
    result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
    checkOutput("ramp_released", {30'd0, result_valid, busy}, 32'd0);

    runCase("tie", vec_tie, 4'd3, 8'hFD);
    runCase("min_pad", vec_min, 4'd0, 8'h80);
    runCase("signed", vec_sign, 4'd5, 8'h01);

    // Back-pressure: outputs hold and fc2_done is ignored while in DONE.
    applyStimulus(vec_ramp);
    waitValid(got_valid);
    checkOutput("hold_valid", 32'(got_valid), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fc2_done = (i == 5);
      if (!result_valid || result_class != 4'd9 || result_score != 8'd10 ||
          sram_raddr_f != 10'd0 || !busy) stable = 1'b0;
    end
    fc2_done = 1'b0;
    checkOutput("hold_stable", 32'(stable), 32'd1);
    result_ready = 1'b1;
    fc2_done     = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    fc2_done     = 1'b0;
    checkOutput("hold_released", {30'd0, result_valid, busy}, 32'd0);
    @(negedge clk);
    checkOutput("hold_no_restart", {22'd0, sram_raddr_f, 1'b0, busy}, 32'd0);

    // Reset in the second READ cycle aborts; a fresh run then completes correctly.
    applyStimulus(vec_ramp);
    @(negedge clk);
    srstn = 1'b0;
    #1;
    checkOutput("abort_raddr", 32'(sram_raddr_f), 32'd0);
    checkOutput("abort_class", 32'(result_class), 32'd0);
    checkOutput("abort_score", 32'(result_score), 32'd0);
    checkOutput("abort_valid", 32'(result_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(negedge clk) srstn = 1'b1;
    @(negedge clk);
    runCase("after_abort", vec_tie, 4'd3, 8'hFD);

    checkOutput("raddr_bound", 32'(raddr_over), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
